pipeline_hazard_ctrl: RTL and testbench

- Drives the four latch-state controls of the 5-stage pipeline: fd_state, de_state, em_state and mw_state.
- Drives the PC enable.
- Latches sample the pipe_state_t each cycle and ENABLE, STALL or FLUSH accordingly.
- Resolves instruction/data memory waits, load-use hazards, MEM-stage redirects and halt drain, and keeps hazard statistics.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
// pipe_state_t : per-latch control (enable, stall/hold, flush/bubble).
// hz_state_t   : hazard controller FSM state.
// load_use_hazard() : true when a load in EX writes a register read in DEC.
package cpu_types_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_FLUSH  = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_HALTED = 2'd2
  } hz_state_t;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(input logic                ld,
                                           input logic [RegAddrW-1:0] wsel,
                                           input logic [RegAddrW-1:0] rs,
                                           input logic [RegAddrW-1:0] rt);
    return ld && (wsel != '0) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master : datapath side, drives hazard sources, receives latch controls.
// slave  : hazard controller, receives hazard sources, drives latch controls,
//          PC enable, halt/watchdog flags and statistics counters.
interface pipeline_hazard_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic                ihit;
  logic                dhit;
  logic                dREN_mem;
  logic                dWEN_mem;
  logic                dREN_ex;
  logic [RegAddrW-1:0] regWSEL_ex;
  logic [RegAddrW-1:0] rs_dec;
  logic [RegAddrW-1:0] rt_dec;
  logic                redirect_mem;
  logic                halt_mem;
  logic                halt_wb;

  pipe_state_t         fd_state;
  pipe_state_t         de_state;
  pipe_state_t         em_state;
  pipe_state_t         mw_state;
  logic                pc_en;
  logic                halted;
  logic                stall_timeout;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, regWSEL_ex, rs_dec, rt_dec,
           redirect_mem, halt_mem, halt_wb,
    input  fd_state, de_state, em_state, mw_state, pc_en, halted, stall_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, regWSEL_ex, rs_dec, rt_dec,
           redirect_mem, halt_mem, halt_wb,
    output fd_state, de_state, em_state, mw_state, pc_en, halted, stall_timeout,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// clk_i : clock           rst_i : synchronous reset (highest priority)
// clr_i : clear to zero   inc_i : increment (holds at all-ones)
// cnt_o : current count
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline.
// Drives the fd/de/em/mw latch controls and the PC enable from the FSM state
// and the current hazard inputs (combinational, zero latency). Handles memory
// waits, MEM-stage redirects, load-use stalls, halt drain, and keeps
// saturating stall/flush statistics plus a sticky memory-wait watchdog.
// CLK : clock          RST : synchronous active-high reset
// hz  : slave side of pipeline_hazard_ctrl_if (all other signals)
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned WaitW = $clog2(STALL_LIMIT + 1);

  hz_state_t        state_q, state_d;
  logic             timeout_q, timeout_d;
  logic             dwait, loaduse;
  logic             stall_ev, flush_ev, dwait_ev;
  logic [WaitW-1:0] wait_cnt;
  pipe_state_t      fd_st, de_st, em_st, mw_st;
  logic             pc_en;

  assign dwait   = (hz.dREN_mem | hz.dWEN_mem) & ~hz.dhit;
  assign loaduse = load_use_hazard(hz.dREN_ex, hz.regWSEL_ex, hz.rs_dec, hz.rt_dec);

  always_comb begin
    state_d  = state_q;
    fd_st    = PIPE_ENABLE;
    de_st    = PIPE_ENABLE;
    em_st    = PIPE_ENABLE;
    mw_st    = PIPE_ENABLE;
    pc_en    = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    dwait_ev = 1'b0;
    if (RST) begin
      fd_st = PIPE_FLUSH;
      de_st = PIPE_FLUSH;
      em_st = PIPE_FLUSH;
      mw_st = PIPE_FLUSH;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (dwait) begin
            // Freeze everything upstream of MEM; bubble into WB.
            fd_st    = PIPE_STALL;
            de_st    = PIPE_STALL;
            em_st    = PIPE_STALL;
            mw_st    = PIPE_FLUSH;
            stall_ev = 1'b1;
            dwait_ev = 1'b1;
          end else if (hz.redirect_mem) begin
            // PC takes the target even if the current fetch is incomplete.
            fd_st    = PIPE_FLUSH;
            de_st    = PIPE_FLUSH;
            em_st    = PIPE_FLUSH;
            pc_en    = 1'b1;
            flush_ev = 1'b1;
          end else if (hz.halt_mem) begin
            fd_st   = PIPE_FLUSH;
            de_st   = PIPE_FLUSH;
            em_st   = PIPE_FLUSH;
            state_d = HZ_DRAIN;
          end else if (loaduse) begin
            // Takes precedence over !ihit: holding fd keeps the pending fetch.
            fd_st    = PIPE_STALL;
            de_st    = PIPE_FLUSH;
            stall_ev = 1'b1;
          end else if (!hz.ihit) begin
            fd_st    = PIPE_FLUSH;
            stall_ev = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
        HZ_DRAIN: begin
          fd_st = PIPE_FLUSH;
          de_st = PIPE_FLUSH;
          em_st = PIPE_FLUSH;
          if (hz.halt_wb) begin
            state_d = HZ_HALTED;
          end
        end
        HZ_HALTED: begin
          fd_st = PIPE_STALL;
          de_st = PIPE_STALL;
          em_st = PIPE_STALL;
          mw_st = PIPE_STALL;
        end
        default: begin
          state_d = HZ_RUN;
        end
      endcase
    end
  end

  // Sets on the dwait cycle that brings the consecutive count up to the limit.
  assign timeout_d = timeout_q |
                     (dwait_ev && ((32'(wait_cnt) + 32'd1) >= STALL_LIMIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HZ_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (1'b0),
    .inc_i (stall_ev),
    .cnt_o (hz.stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (1'b0),
    .inc_i (flush_ev),
    .cnt_o (hz.flush_cnt)
  );

  sat_counter #(
    .Width (WaitW)
  ) u_wait_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (~dwait_ev),
    .inc_i (dwait_ev),
    .cnt_o (wait_cnt)
  );

  assign hz.fd_state      = fd_st;
  assign hz.de_state      = de_st;
  assign hz.em_state      = em_st;
  assign hz.mw_state      = mw_st;
  assign hz.pc_en         = pc_en;
  assign hz.halted        = (state_q == HZ_HALTED) & ~RST;
  assign hz.stall_timeout = timeout_q & ~RST;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (STALL_LIMIT reduced to 4).
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned Limit = 4;

  typedef struct {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       drm;
    logic       dwm;
    logic       dre;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       redir;
    logic       hmem;
    logic       hwb;
  } vec_t;

  typedef struct {
    logic [1:0]  fd, de, em, mw;
    logic        pc_en, halted, timeout;
    logic [31:0] stall, flush;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  // Reference model state
  int          m_st;  // 0 run, 1 drain, 2 halted
  logic        m_timeout;
  logic [31:0] m_stall, m_flush;
  int          m_wait;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz_if ();

  pipeline_hazard_ctrl #(
    .CNT_W       (32),
    .STALL_LIMIT (Limit)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .hz  (hz_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{rst: 1'b0, ihit: 1'b1, dhit: 1'b0, drm: 1'b0, dwm: 1'b0, dre: 1'b0,
          wsel: 5'd0, rs: 5'd0, rt: 5'd0, redir: 1'b0, hmem: 1'b0, hwb: 1'b0};
    return v;
  endfunction

  function automatic exp_t set4(input exp_t e, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [1:0] d, input logic pc);
    exp_t r;
    r = e;
    r.fd = a; r.de = b; r.em = c; r.mw = d; r.pc_en = pc;
    return r;
  endfunction

  function automatic exp_t model_eval(input vec_t v);
    exp_t e;
    logic dw, lu;
    e.stall   = m_stall;
    e.flush   = m_flush;
    e.halted  = !v.rst && (m_st == 2);
    e.timeout = !v.rst && m_timeout;
    e = set4(e, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    dw = (v.drm || v.dwm) && !v.dhit;
    lu = v.dre && (v.wsel != 5'd0) && ((v.wsel == v.rs) || (v.wsel == v.rt));
    if (v.rst)          e = set4(e, 2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
    else if (m_st == 1) e = set4(e, 2'd2, 2'd2, 2'd2, 2'd0, 1'b0);
    else if (m_st == 2) e = set4(e, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0);
    else if (dw)        e = set4(e, 2'd1, 2'd1, 2'd1, 2'd2, 1'b0);
    else if (v.redir)   e = set4(e, 2'd2, 2'd2, 2'd2, 2'd0, 1'b1);
    else if (v.hmem)    e = set4(e, 2'd2, 2'd2, 2'd2, 2'd0, 1'b0);
    else if (lu)        e = set4(e, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0);
    else if (!v.ihit)   e = set4(e, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
    else                e = set4(e, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    return e;
  endfunction

  task automatic model_update(input vec_t v);
    logic dw, lu;
    dw = (v.drm || v.dwm) && !v.dhit;
    lu = v.dre && (v.wsel != 5'd0) && ((v.wsel == v.rs) || (v.wsel == v.rt));
    if (v.rst) begin
      m_st = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
    end else if (m_st == 0) begin
      if (dw) begin
        if (m_stall != 32'hffff_ffff) m_stall++;
        m_wait++;
        if (m_wait >= Limit) m_timeout = 1'b1;
      end else begin
        m_wait = 0;
        if (v.redir) begin
          if (m_flush != 32'hffff_ffff) m_flush++;
        end else if (v.hmem) begin
          m_st = 1;
        end else if (lu || !v.ihit) begin
          if (m_stall != 32'hffff_ffff) m_stall++;
        end
      end
    end else begin
      m_wait = 0;
      if (m_st == 1 && v.hwb) m_st = 2;
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    rst                = v.rst;
    hz_if.ihit         = v.ihit;
    hz_if.dhit         = v.dhit;
    hz_if.dREN_mem     = v.drm;
    hz_if.dWEN_mem     = v.dwm;
    hz_if.dREN_ex      = v.dre;
    hz_if.regWSEL_ex   = v.wsel;
    hz_if.rs_dec       = v.rs;
    hz_if.rt_dec       = v.rt;
    hz_if.redirect_mem = v.redir;
    hz_if.halt_mem     = v.hmem;
    hz_if.halt_wb      = v.hwb;
    exp_q.push_back(model_eval(v));
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("fd_state", 32'(hz_if.fd_state), 32'(e.fd));
    check_val("de_state", 32'(hz_if.de_state), 32'(e.de));
    check_val("em_state", 32'(hz_if.em_state), 32'(e.em));
    check_val("mw_state", 32'(hz_if.mw_state), 32'(e.mw));
    check_val("pc_en", 32'(hz_if.pc_en), 32'(e.pc_en));
    check_val("halted", 32'(hz_if.halted), 32'(e.halted));
    check_val("stall_timeout", 32'(hz_if.stall_timeout), 32'(e.timeout));
    check_val("stall_cnt", hz_if.stall_cnt, e.stall);
    check_val("flush_cnt", hz_if.flush_cnt, e.flush);
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    m_st = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
    v = idle();
    v.rst = 1'b1;
    // Unchecked initial reset so every register leaves X.
    rst = 1'b1;
    hz_if.ihit = 1'b1; hz_if.dhit = 1'b0; hz_if.dREN_mem = 1'b0; hz_if.dWEN_mem = 1'b0;
    hz_if.dREN_ex = 1'b0; hz_if.regWSEL_ex = 5'd0; hz_if.rs_dec = 5'd0; hz_if.rt_dec = 5'd0;
    hz_if.redirect_mem = 1'b0; hz_if.halt_mem = 1'b0; hz_if.halt_wb = 1'b0;
    @(posedge clk);
    #1;
    apply(v);

    // Normal flow
    apply(idle());
    apply(idle());

    // Load-use on rs, then on rt, then r0 (no hazard)
    v = idle(); v.dre = 1'b1; v.wsel = 5'd5; v.rs = 5'd5; v.rt = 5'd1;
    apply(v);
    v.rs = 5'd2; v.rt = 5'd5;
    apply(v);
    v = idle(); v.dre = 1'b1; v.wsel = 5'd0; v.rs = 5'd0;
    apply(v);
    apply(idle());

    // Store waits three cycles, then completes
    v = idle(); v.dwm = 1'b1;
    repeat (3) apply(v);
    v.dhit = 1'b1;
    apply(v);
    apply(idle());

    // Watchdog: exactly STALL_LIMIT consecutive waits, then hit
    v = idle(); v.rst = 1'b1;
    apply(v);
    v = idle(); v.drm = 1'b1;
    repeat (Limit) apply(v);
    v.dhit = 1'b1;
    apply(v);
    apply(idle());

    // Redirect with fetch miss, redirect beats halt, dwait beats redirect
    v = idle(); v.ihit = 1'b0; v.redir = 1'b1;
    apply(v);
    v.hmem = 1'b1; v.ihit = 1'b1;
    apply(v);
    v = idle(); v.drm = 1'b1; v.redir = 1'b1;
    apply(v);
    // Load-use with fetch miss
    v = idle(); v.ihit = 1'b0; v.dre = 1'b1; v.wsel = 5'd7; v.rt = 5'd7;
    apply(v);
    v = idle(); v.ihit = 1'b0;
    apply(v);

    // Halt, drain one cycle, halted, then reset
    v = idle(); v.rst = 1'b1;
    apply(v);
    v = idle(); v.hmem = 1'b1;
    apply(v);
    v = idle(); v.hwb = 1'b1;
    apply(v);
    v = idle(); v.drm = 1'b1; v.redir = 1'b1;
    repeat (2) apply(v);
    v = idle(); v.rst = 1'b1;
    apply(v);
    apply(idle());

    // Reset mid-drain and mid-stall
    v = idle(); v.hmem = 1'b1;
    apply(v);
    v = idle(); v.rst = 1'b1;
    apply(v);
    apply(idle());
    v = idle(); v.dwm = 1'b1;
    repeat (2) apply(v);
    v.rst = 1'b1;
    apply(v);
    apply(idle());

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v.rst   = ($urandom_range(0, 59) == 0);
      v.ihit  = ($urandom_range(0, 3) != 0);
      v.dhit  = ($urandom_range(0, 2) != 0);
      v.drm   = ($urandom_range(0, 3) == 0);
      v.dwm   = ($urandom_range(0, 5) == 0);
      v.dre   = $urandom_range(0, 1);
      v.wsel  = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.redir = ($urandom_range(0, 7) == 0);
      v.hmem  = ($urandom_range(0, 39) == 0);
      v.hwb   = ($urandom_range(0, 2) == 0);
      apply(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
